// File: rtl/pairing_job_scheduler_if.sv
// Request/response and pairing-core signal bundle for pairing_job_scheduler.
// The slave modport is the scheduler's view; master is the system/core side.
interface pairing_job_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned M    = 97
);
  localparam int unsigned OPW  = 2 * M;
  localparam int unsigned RESW = 12 * M;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_x1;
  logic [NREQ*OPW-1:0] req_y1;
  logic [NREQ*OPW-1:0] req_x2;
  logic [NREQ*OPW-1:0] req_y2;
  logic                resp_valid;
  logic                resp_ready;
  logic [2:0]          resp_id;
  logic                resp_err;
  logic [RESW-1:0]     resp_data;
  logic                busy;
  logic                core_rst;
  logic [OPW-1:0]      core_x1;
  logic [OPW-1:0]      core_y1;
  logic [OPW-1:0]      core_x2;
  logic [OPW-1:0]      core_y2;
  logic                core_done;
  logic [RESW-1:0]     core_out;

  modport slave (
    input  req_valid, req_x1, req_y1, req_x2, req_y2, resp_ready, core_done, core_out,
    output req_ready, resp_valid, resp_id, resp_err, resp_data, busy,
           core_rst, core_x1, core_y1, core_x2, core_y2
  );

  modport master (
    output req_valid, req_x1, req_y1, req_x2, req_y2, resp_ready, core_done, core_out,
    input  req_ready, resp_valid, resp_id, resp_err, resp_data, busy,
           core_rst, core_x1, core_y1, core_x2, core_y2
  );
endinterface

// File: rtl/pairing_job_scheduler.sv
// Round-robin scheduler sharing one pairing core among NREQ requesters:
// accept, pulse core reset, run under a watchdog, return the tagged result.
module pairing_job_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned M          = 97,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1048576
) (
  input  logic                     clk,
  input  logic                     reset,
  pairing_job_scheduler_if.slave   io_bus
);
  localparam int unsigned OPW  = 2 * M;
  localparam int unsigned RESW = 12 * M;
  localparam int unsigned IDW  = 3;
  localparam int unsigned RCW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [RCW-1:0]  r_rst_cnt;
  logic [WDW-1:0]  r_wdog;
  logic            r_core_rst;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic            r_busy;
  logic [RESW-1:0] r_data;
  logic [OPW-1:0]  r_x1, r_y1, r_x2, r_y2;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic              w_found;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_grant;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [NREQ-1:0]   w_ready;
  logic              w_accept;
  logic [OPW-1:0]    w_x1, w_y1, w_x2, w_y2;

  // Rotate requests so the search always starts at bit 0, then pick the lowest set bit.
  always_comb begin
    w_dbl   = {io_bus.req_valid, io_bus.req_valid};
    w_rot   = NREQ'(w_dbl >> r_ptr);
    w_off   = '0;
    w_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_grant   = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
    w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
    w_ready   = (r_state == S_IDLE && w_found && !reset) ? (NREQ'(1) << w_grant) : '0;
    w_accept  = |(w_ready & io_bus.req_valid);
  end

  // Select the granted requester's operand slices.
  always_comb begin
    w_x1 = '0;
    w_y1 = '0;
    w_x2 = '0;
    w_y2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_x1 = io_bus.req_x1[i*OPW +: OPW];
        w_y1 = io_bus.req_y1[i*OPW +: OPW];
        w_x2 = io_bus.req_x2[i*OPW +: OPW];
        w_y2 = io_bus.req_y2[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_rst_cnt    <= '0;
      r_wdog       <= '0;
      r_core_rst   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_data       <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_x2         <= '0;
      r_y2         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x1       <= w_x1;
            r_y1       <= w_y1;
            r_x2       <= w_x2;
            r_y2       <= w_y2;
            r_id       <= w_grant;
            r_ptr      <= w_ptr_nxt;
            r_rst_cnt  <= '0;
            r_wdog     <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (r_rst_cnt == RCW'(RST_CYCLES - 1)) begin
            r_core_rst <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
          end
        end
        S_RUN: begin
          r_wdog <= r_wdog + WDW'(1);
          // A done level in the timeout cycle still counts as success.
          if (io_bus.core_done) begin
            r_data       <= io_bus.core_out;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
            r_data       <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_core_rst   <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_core_rst <= 1'b0;
          if (io_bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready  = w_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_id    = r_id;
  assign io_bus.resp_err   = r_resp_err;
  assign io_bus.resp_data  = r_data;
  assign io_bus.busy       = r_busy;
  // The core is held in reset for as long as the scheduler is.
  assign io_bus.core_rst   = r_core_rst | reset;
  assign io_bus.core_x1    = r_x1;
  assign io_bus.core_y1    = r_y1;
  assign io_bus.core_x2    = r_x2;
  assign io_bus.core_y2    = r_y2;
endmodule
